i2c_target_responder: RTL and testbench

- Synthesizable, parametrised I2C target (slave) responder for the IICMB multi-bus test system, one instance per I2C bus.
- Oversamples SCL/SDA on the system clock. Detects START, repeated START and STOP. Matches a configurable 7-bit address, ACKs it, stores write bytes into an internal buffer and returns buffer bytes on reads.
- Adds over the class-based I2C driver: a byte buffer of configurable depth, a configurable sync depth, and a listen-only mode that never drives the bus.

---
 rtl/i2c_target_responder.sv | 207 ++++++++++++++++++++
 tb/tb_i2c_target_responder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_responder.sv
// I2C target responder: oversampled SCL/SDA, 7-bit address match,
// byte buffer written by master writes and returned on master reads.
module i2c_target_responder #(
  parameter logic [6:0] TARGET_ADDR = 7'h22,
  parameter int         BUF_DEPTH   = 16,
  parameter int         SYNC_STAGES = 2,
  parameter bit         LISTEN_ONLY = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        scl_i,
  input  logic                        sda_i,
  output logic                        sda_oe,
  output logic                        busy,
  output logic                        addr_match,
  output logic                        wr_strobe,
  output logic [7:0]                  wr_data,
  output logic [$clog2(BUF_DEPTH):0]  byte_count
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(BUF_DEPTH);
  localparam logic [AW:0] CNT_MAX = '1;
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WRITE,
    WR_ACK, READ, RD_ACK, IGNORE
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_dly_q;
  logic                   sda_dly_q;
  logic [3:0]             cnt_q;
  logic [6:0]             sh_q;
  logic [7:0]             tx_q;
  logic                   rw_q;
  logic                   ack_q;
  logic                   ack_ok_q;
  logic                   oe_q;
  logic [AW:0]            ptr_q;
  logic [7:0]             mem_q [BUF_DEPTH];

  logic          scl_s, sda_s;
  logic          scl_rise, scl_fall;
  logic          start_det, stop_det;
  logic [7:0]    rx_byte;
  logic [AW-1:0] idx, idx_nxt;
  logic          room, mem_we;

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_dly_q;
  assign scl_fall  = ~scl_s & scl_dly_q;
  assign start_det = scl_s & sda_dly_q & ~sda_s;
  assign stop_det  = scl_s & ~sda_dly_q & sda_s;
  assign rx_byte   = {sh_q, sda_s};
  assign idx       = ptr_q[AW-1:0];
  assign idx_nxt   = idx + AW'(1);
  assign room      = ptr_q < DEPTH_C;
  assign mem_we    = (state_q == WRITE) & scl_rise
                   & (cnt_q == 4'd7) & room
                   & ~start_det & ~stop_det;

  assign sda_oe = oe_q & ~LISTEN_ONLY;

  // Buffer contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= rx_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
      cnt_q      <= '0;
      sh_q       <= '0;
      tx_q       <= '0;
      rw_q       <= 1'b0;
      ack_q      <= 1'b0;
      ack_ok_q   <= 1'b0;
      oe_q       <= 1'b0;
      ptr_q      <= '0;
      busy       <= 1'b0;
      addr_match <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_data    <= '0;
      byte_count <= '0;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_dly_q  <= scl_s;
      sda_dly_q  <= sda_s;
      wr_strobe  <= 1'b0;
      if (start_det) begin
        state_q    <= ADDR;
        cnt_q      <= '0;
        ptr_q      <= '0;
        byte_count <= '0;
        busy       <= 1'b1;
        addr_match <= 1'b0;
        oe_q       <= 1'b0;
        ack_q      <= 1'b0;
      end else if (stop_det) begin
        state_q    <= IDLE;
        busy       <= 1'b0;
        addr_match <= 1'b0;
        oe_q       <= 1'b0;
      end else begin
        unique case (state_q)
          ADDR: if (scl_rise) begin
            sh_q  <= rx_byte[6:0];
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_q <= '0;
              rw_q  <= sda_s;
              ack_q <= 1'b0;
              if (rx_byte[7:1] == TARGET_ADDR) begin
                addr_match <= 1'b1;
                state_q    <= ADDR_ACK;
              end else begin
                state_q <= IGNORE;
              end
            end
          end
          // First falling edge starts the ACK, second one ends it.
          ADDR_ACK: if (scl_fall) begin
            if (!ack_q) begin
              oe_q  <= 1'b1;
              ack_q <= 1'b1;
            end else begin
              ack_q <= 1'b0;
              cnt_q <= '0;
              if (rw_q) begin
                state_q <= READ;
                oe_q    <= ~mem_q[idx][7];
                tx_q    <= {mem_q[idx][6:0], 1'b0};
              end else begin
                state_q <= WRITE;
                oe_q    <= 1'b0;
              end
            end
          end
          WRITE: if (scl_rise) begin
            sh_q  <= rx_byte[6:0];
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_q    <= '0;
              ack_q    <= 1'b0;
              ack_ok_q <= room;
              state_q  <= WR_ACK;
              if (room) begin
                wr_strobe  <= 1'b1;
                wr_data    <= rx_byte;
                ptr_q      <= ptr_q + ONE_C;
                byte_count <= byte_count + ONE_C;
              end
            end
          end
          WR_ACK: if (scl_fall) begin
            if (!ack_q) begin
              oe_q  <= ack_ok_q;
              ack_q <= 1'b1;
            end else begin
              oe_q    <= 1'b0;
              ack_q   <= 1'b0;
              state_q <= WRITE;
            end
          end
          READ: begin
            if (scl_rise && cnt_q != 4'd8)
              cnt_q <= cnt_q + 4'd1;
            if (scl_fall) begin
              if (cnt_q == 4'd8) begin
                oe_q    <= 1'b0;
                cnt_q   <= '0;
                state_q <= RD_ACK;
              end else begin
                oe_q <= ~tx_q[7];
                tx_q <= {tx_q[6:0], 1'b0};
              end
            end
          end
          RD_ACK: if (scl_rise) begin
            if (byte_count != CNT_MAX)
              byte_count <= byte_count + ONE_C;
            if (!sda_s) begin
              ptr_q   <= {1'b0, idx_nxt};
              tx_q    <= mem_q[idx_nxt];
              cnt_q   <= '0;
              state_q <= READ;
            end else begin
              state_q <= IGNORE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench for i2c_target_responder: bit-banged I2C master against three
// instances (default, 4-entry buffer, listen-only) with a scoreboard.
module tb_i2c_target_responder;

  localparam int Q = 8;

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  logic clk, rst;
  logic scl_m, sda_m;
  int   sel;
  logic line;

  logic [2:0] scl_p, sda_p, oe, bsy, am, ws;
  logic [7:0] wd [3];
  logic [4:0] bc0, bcl;
  logic [2:0] bc4;

  logic [7:0] exp_wr [$];
  exp_t       exp_bus [$];
  logic [7:0] obs_val;
  event       obs_ev;
  int         oe_cnt;
  int         passed, total;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign line = sda_m & ~oe[sel];
  for (genvar k = 0; k < 3; k++) begin : g_bus
    assign scl_p[k] = (sel == k) ? scl_m : 1'b1;
    assign sda_p[k] = (sel == k) ? line : 1'b1;
  end

  i2c_target_responder u_main (
    .clk(clk), .rst(rst), .scl_i(scl_p[0]), .sda_i(sda_p[0]),
    .sda_oe(oe[0]), .busy(bsy[0]), .addr_match(am[0]),
    .wr_strobe(ws[0]), .wr_data(wd[0]), .byte_count(bc0)
  );

  i2c_target_responder #(.BUF_DEPTH(4)) u_d4 (
    .clk(clk), .rst(rst), .scl_i(scl_p[1]), .sda_i(sda_p[1]),
    .sda_oe(oe[1]), .busy(bsy[1]), .addr_match(am[1]),
    .wr_strobe(ws[1]), .wr_data(wd[1]), .byte_count(bc4)
  );

  i2c_target_responder #(.LISTEN_ONLY(1'b1)) u_lo (
    .clk(clk), .rst(rst), .scl_i(scl_p[2]), .sda_i(sda_p[2]),
    .sda_oe(oe[2]), .busy(bsy[2]), .addr_match(am[2]),
    .wr_strobe(ws[2]), .wr_data(wd[2]), .byte_count(bcl)
  );

  task automatic check(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask

  task automatic wq();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic i2c_bit(input logic b, output logic r);
    sda_m = b; wq();
    scl_m = 1'b1; wq();
    r = line; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b1;
  endtask

  task automatic exp_ack(input string n, input logic a);
    exp_t e;
    e.name = n;
    e.val  = {7'd0, a};
    exp_bus.push_back(e);
  endtask

  task automatic exp_rd(input string n, input logic [7:0] d);
    exp_t e;
    e.name = n;
    e.val  = d;
    exp_bus.push_back(e);
  endtask

  task automatic send(input logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) i2c_bit(d[i], r);
    i2c_bit(1'b1, r);
    obs_val = {7'd0, ~r};
    ->obs_ev;
  endtask

  task automatic recv(input logic mack);
    logic r;
    logic [7:0] d;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      i2c_bit(1'b1, r);
      d = {d[6:0], r};
    end
    obs_val = d;
    ->obs_ev;
    i2c_bit(~mack, r);
  endtask

  initial begin
    int snap;
    logic r;
    passed = 0; total = 0; oe_cnt = 0;
    sel = 0; scl_m = 1'b1; sda_m = 1'b1;
    rst = 1'b1;

    fork
      forever begin
        logic [7:0] e;
        @(negedge clk);
        if (oe[sel]) oe_cnt++;
        if (ws[sel]) begin
          total++;
          if (exp_wr.size() == 0) begin
            $display("FAIL wr_strobe: unexpected data %02h, none expected", wd[sel]);
          end else begin
            e = exp_wr.pop_front();
            if (wd[sel] === e) passed++;
            else $display("FAIL wr_data: got %02h expected %02h", wd[sel], e);
          end
        end
      end
      forever begin
        exp_t x;
        @(obs_ev);
        total++;
        if (exp_bus.size() == 0) begin
          $display("FAIL bus: unexpected observation %02h", obs_val);
        end else begin
          x = exp_bus.pop_front();
          if (obs_val === x.val) passed++;
          else $display("FAIL %s: got %02h expected %02h", x.name, obs_val, x.val);
        end
      end
    join_none

    repeat (4) @(posedge clk);
    #1;
    check("rst_busy", 32'(bsy[0]), 0);
    check("rst_oe", 32'(oe[0]), 0);
    check("rst_addr_match", 32'(am[0]), 0);
    check("rst_wr_data", 32'(wd[0]), 0);
    check("rst_byte_count", 32'(bc0), 0);
    rst = 1'b0;
    wq();

    // Preload buf[2] so the later read has a known third byte.
    i2c_start();
    exp_ack("pre_addr_ack", 1'b1); send(8'h44);
    foreach (exp_wr[i]) ;
    exp_wr.push_back(8'h11); exp_ack("pre_d0_ack", 1'b1); send(8'h11);
    exp_wr.push_back(8'h22); exp_ack("pre_d1_ack", 1'b1); send(8'h22);
    exp_wr.push_back(8'h5A); exp_ack("pre_d2_ack", 1'b1); send(8'h5A);
    i2c_stop(); wq();

    // Write A5, 3C then STOP.
    i2c_start();
    exp_ack("w_addr_ack", 1'b1); send(8'h44);
    check("w_addr_match", 32'(am[0]), 1);
    exp_wr.push_back(8'hA5); exp_ack("w_d0_ack", 1'b1); send(8'hA5);
    exp_wr.push_back(8'h3C); exp_ack("w_d1_ack", 1'b1); send(8'h3C);
    check("w_byte_count", 32'(bc0), 2);
    check("w_busy", 32'(bsy[0]), 1);
    i2c_stop();
    repeat (2) @(posedge clk);
    #1;
    check("stop_busy_2clk", 32'(bsy[0]), 1);
    @(posedge clk);
    #1;
    check("stop_busy_3clk", 32'(bsy[0]), 0);
    wq();

    // Write address, repeated START, read 3 bytes.
    i2c_start();
    exp_ack("rs_waddr_ack", 1'b1); send(8'h44);
    i2c_start();
    exp_ack("r_addr_ack", 1'b1); send(8'h45);
    exp_rd("r_byte0", 8'hA5); recv(1'b1);
    exp_rd("r_byte1", 8'h3C); recv(1'b1);
    exp_rd("r_byte2", 8'h5A); recv(1'b0);
    check("r_byte_count", 32'(bc0), 3);
    check("r_oe_after_nack", 32'(oe[0]), 0);
    i2c_stop(); wq();
    check("r_stop_oe", 32'(oe[0]), 0);
    check("r_stop_busy", 32'(bsy[0]), 0);

    // Wrong address 0x23.
    snap = oe_cnt;
    i2c_start();
    exp_ack("nm_addr_ack", 1'b0); send(8'h46);
    check("nm_addr_match", 32'(am[0]), 0);
    exp_ack("nm_d_ack", 1'b0); send(8'h99);
    i2c_stop(); wq();
    check("nm_oe_cycles", 32'(oe_cnt - snap), 0);

    // 4-entry buffer overflow.
    sel = 1;
    wq();
    i2c_start();
    exp_ack("d4_addr_ack", 1'b1); send(8'h44);
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) begin
        exp_wr.push_back(8'(i));
        exp_ack($sformatf("d4_d%0d_ack", i), 1'b1);
      end else begin
        exp_ack("d4_d5_nack", 1'b0);
      end
      send(8'(i));
    end
    check("d4_byte_count", 32'(bc4), 4);
    i2c_stop(); wq();

    // Listen-only target.
    sel = 2;
    wq();
    snap = oe_cnt;
    i2c_start();
    exp_ack("lo_addr_noack", 1'b0); send(8'h44);
    check("lo_addr_match", 32'(am[2]), 1);
    exp_wr.push_back(8'h77); exp_ack("lo_d_noack", 1'b0); send(8'h77);
    check("lo_byte_count", 32'(bcl), 1);
    i2c_stop(); wq();
    check("lo_oe_cycles", 32'(oe_cnt - snap), 0);

    // Reset while driving bit 4 (a 0) of a read byte.
    sel = 0;
    wq();
    i2c_start();
    exp_ack("rr_addr_ack", 1'b1); send(8'h45);
    for (int i = 0; i < 3; i++) i2c_bit(1'b1, r);
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    check("rr_bit4_driven", 32'(oe[0]), 1);
    #3 rst = 1'b1;
    #1;
    check("rr_rst_oe", 32'(oe[0]), 0);
    check("rr_rst_busy", 32'(bsy[0]), 0);
    repeat (3) @(posedge clk);
    #4 rst = 1'b0;
    wq();
    i2c_start();
    exp_ack("post_addr_ack", 1'b1); send(8'h44);
    exp_wr.push_back(8'hC3); exp_ack("post_d_ack", 1'b1); send(8'hC3);
    check("post_byte_count", 32'(bc0), 1);
    i2c_stop(); wq();
    check("post_busy", 32'(bsy[0]), 0);

    wq();
    check("wr_queue_drained", 32'(exp_wr.size()), 0);
    check("bus_queue_drained", 32'(exp_bus.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
